// File: rtl/pipeline_pkg.sv
// Shared pipeline types and defaults.
// IF/ID bundle is reused by later stages.
package pipeline_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0] instr;
    logic valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Flush forces a bubble and wins over the write enable.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   write,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: d.pc, instr: NOP_INSTR, valid: 1'b0};
    end else if (write) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, next-PC select, imem handshake
// and the IF/ID register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCwrite,
  input  logic            IF_IDwrite,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  fetch_state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] addr, addr_n;
  logic [XLEN-1:0] tgt;
  logic req, fire, take;
  logic unused;
  if_id_t if_id_d, if_id_q;

  assign tgt = {branch_target[XLEN-1:2], 2'b00};
  assign unused = ^branch_target[1:0];
  assign fire = req & imem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else state <= state_n;
  end

  // A flush with a request still in flight must
  // let that wrong-path transfer finish first.
  always_comb begin
    state_n = state;
    unique case (state)
      FETCH: if (flush && req && !imem_ready) state_n = DRAIN;
      DRAIN: if (imem_ready) state_n = FETCH;
    endcase
  end

  always_comb begin
    take = (state == FETCH) && fire && PCwrite;
    pc_n = pc;
    if (flush) pc_n = tgt;
    else if (take) pc_n = pc + XLEN'(4);
    addr_n = (state_n == FETCH) ? pc_n : addr;
    if_id_d.pc = pc;
    if_id_d.instr = take ? imem_rdata : NOP_INSTR;
    if_id_d.valid = take;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      addr <= RESET_PC;
      req  <= 1'b0;
    end else begin
      pc   <= pc_n;
      addr <= addr_n;
      req  <= 1'b1;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .write(IF_IDwrite),
    .flush(flush),
    .d    (if_id_d),
    .q    (if_id_q)
  );

  assign imem_req = req;
  assign imem_addr = addr;
  assign if_id_pc = if_id_q.pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_valid = if_id_q.valid;

endmodule
